// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one registered 32-bit ALU between two requesters
// Optional macro ALU_OUT_REG_EN adds a WAIT state and a second result stage after the ALU.
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [9:0]       req_op,
  input  logic [63:0]      req_a,
  input  logic [63:0]      req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_y,
  output logic             rsp_z,
  output logic             rsp_v,
  output logic             rsp_n,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [4:0]       alu_op,
  input  logic [31:0]      alu_y,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_n,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

`ifdef ALU_OUT_REG_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd3} state_t;
`endif

  state_t            r_state;
  logic              r_last_grant;
  logic [4:0]        r_op;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic              r_id;
  logic [31:0]       r_y;
  logic              r_z;
  logic              r_v;
  logic              r_n;
  logic              r_rsp_valid;
  logic              r_busy;
  logic [CNT_W-1:0]  r_done_cnt;
`ifdef ALU_OUT_REG_EN
  logic [31:0]       r_s1_y;
  logic              r_s1_z;
  logic              r_s1_v;
  logic              r_s1_n;
`endif

  logic w_grant;
  logic w_accept;

  // With both requesters valid the one that did not win last time gets the slot.
  assign w_grant  = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
  assign w_accept = (r_state == S_IDLE) && (req_valid != 2'b00);

  assign req_ready = (w_accept && rst_n) ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_y          <= '0;
      r_z          <= 1'b0;
      r_v          <= 1'b0;
      r_n          <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done_cnt   <= '0;
`ifdef ALU_OUT_REG_EN
      r_s1_y       <= '0;
      r_s1_z       <= 1'b0;
      r_s1_v       <= 1'b0;
      r_s1_n       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op         <= w_grant ? req_op[9:5]  : req_op[4:0];
            r_a          <= w_grant ? req_a[63:32] : req_a[31:0];
            r_b          <= w_grant ? req_b[63:32] : req_b[31:0];
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_busy       <= 1'b1;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
`ifdef ALU_OUT_REG_EN
          r_s1_y  <= alu_y;
          r_s1_z  <= alu_z;
          r_s1_v  <= alu_v;
          r_s1_n  <= alu_n;
          r_state <= S_WAIT;
`else
          r_y         <= alu_y;
          r_z         <= alu_z;
          r_v         <= alu_v;
          r_n         <= alu_n;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
`endif
        end
`ifdef ALU_OUT_REG_EN
        S_WAIT: begin
          r_y         <= r_s1_y;
          r_z         <= r_s1_z;
          r_v         <= r_s1_v;
          r_n         <= r_s1_n;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
`endif
        S_RESP: begin
          if (rsp_ready) begin
            r_done_cnt  <= r_done_cnt + 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu_op    = r_op;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_y     = r_y;
  assign rsp_z     = r_z;
  assign rsp_v     = r_v;
  assign rsp_n     = r_n;
  assign busy      = r_busy;
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with an adder ALU stub
module tb_alu_arbiter;

`ifdef ALU_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [9:0]  req_op;
  logic [63:0] req_a, req_b;
  logic        rsp_ready;

  logic [1:0]  req_ready;
  logic        rsp_valid, rsp_id, rsp_z, rsp_v, rsp_n, busy;
  logic [31:0] rsp_y, alu_a, alu_b, alu_y;
  logic [4:0]  alu_op;
  logic        alu_z, alu_v, alu_n;
  logic [15:0] done_cnt;

  logic [1:0]  w2_req_ready;
  logic        w2_rsp_valid, w2_rsp_id, w2_rsp_z, w2_rsp_v, w2_rsp_n, w2_busy;
  logic [31:0] w2_rsp_y, w2_alu_a, w2_alu_b, w2_alu_y;
  logic [4:0]  w2_alu_op;
  logic        w2_alu_z, w2_alu_v, w2_alu_n;
  logic [1:0]  w2_done_cnt;

  always #5 clk = ~clk;

  assign alu_y = alu_a + alu_b;
  assign alu_z = (alu_y == 32'd0);
  assign alu_n = alu_y[31];
  assign alu_v = (alu_a[31] == alu_b[31]) && (alu_y[31] != alu_a[31]);

  assign w2_alu_y = w2_alu_a + w2_alu_b;
  assign w2_alu_z = (w2_alu_y == 32'd0);
  assign w2_alu_n = w2_alu_y[31];
  assign w2_alu_v = (w2_alu_a[31] == w2_alu_b[31]) && (w2_alu_y[31] != w2_alu_a[31]);

  alu_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .rsp_z(rsp_z), .rsp_v(rsp_v), .rsp_n(rsp_n),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
    .busy(busy), .done_cnt(done_cnt)
  );

  alu_arbiter #(.CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(w2_req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(w2_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(w2_rsp_id), .rsp_y(w2_rsp_y),
    .rsp_z(w2_rsp_z), .rsp_v(w2_rsp_v), .rsp_n(w2_rsp_n),
    .alu_a(w2_alu_a), .alu_b(w2_alu_b), .alu_op(w2_alu_op),
    .alu_y(w2_alu_y), .alu_z(w2_alu_z), .alu_v(w2_alu_v), .alu_n(w2_alu_n),
    .busy(w2_busy), .done_cnt(w2_done_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] y;
    y = a + b;
    return {y, (y == 32'd0), ((a[31] == b[31]) && (y[31] != a[31])), y[31]};
  endfunction

  // Scoreboard: expected response pushed on accept, popped on response handshake.
  logic [35:0] sb[$];

  always @(negedge clk) begin : mon
    logic        g;
    logic [35:0] e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (req_ready != 2'b00) begin
        g = req_ready[1];
        sb.push_back({g, alu_model(g ? req_a[63:32] : req_a[31:0], g ? req_b[63:32] : req_b[31:0])});
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_rsp", {28'd0, rsp_id, rsp_y, rsp_z, rsp_v, rsp_n}, {28'd0, e});
        end
      end
    end
  end

  typedef struct {
    logic [1:0]  valid;
    logic [4:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic        exp_id;
    logic [31:0] exp_y;
    logic        exp_z, exp_v, exp_n;
  } vec_t;

  vec_t vecs[6];

  task automatic drive(input logic [1:0] v, input logic [4:0] o0, input logic [4:0] o1,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1);
    req_valid = v;
    req_op    = {o1, o0};
    req_a     = {a1, a0};
    req_b     = {b1, b0};
  endtask

  task automatic wait_ready(output bit ok, output int t);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  task automatic wait_rsp(output bit ok, output int t);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  initial begin
    bit   ok, bp_ok;
    int   t0, t1, nr;
    int   gq[$];

    vecs[0] = '{2'b01, 5'h00, 5'h00, 32'd5,        32'd3,        32'd0,        32'd0,        1'b0, 32'd8,        1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 5'h00, 5'h03, 32'd0,        32'd0,        32'h7FFFFFFF, 32'd1,        1'b1, 32'h80000000, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{2'b01, 5'h1F, 5'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        1'b0, 32'd0,        1'b1, 1'b0, 1'b0};
    vecs[3] = '{2'b10, 5'h00, 5'h0A, 32'd0,        32'd0,        32'h80000000, 32'h80000000, 1'b1, 32'd0,        1'b1, 1'b1, 1'b0};
    vecs[4] = '{2'b01, 5'h11, 5'h00, 32'hFFFFFFFB, 32'd2,        32'd0,        32'd0,        1'b0, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{2'b11, 5'h05, 5'h16, 32'd1,        32'd1,        32'd100,      32'd23,       1'b1, 32'd123,      1'b0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    drive(2'b00, 5'h0, 5'h0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done_cnt", done_cnt, 0);
    chk("reset_alu_regs", {alu_op, alu_a, alu_b}, 0);
    chk("reset_rsp_regs", {rsp_id, rsp_y, rsp_z, rsp_v, rsp_n}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      drive(vecs[k].valid, vecs[k].op0, vecs[k].op1, vecs[k].a0, vecs[k].b0, vecs[k].a1, vecs[k].b1);
      wait_ready(ok, t0);
      chk($sformatf("v%0d_accept", k), ok, 1);
      chk($sformatf("v%0d_grant", k), req_ready, vecs[k].exp_id ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      req_valid = 2'b00;
      wait_rsp(ok, t1);
      chk($sformatf("v%0d_rsp_seen", k), ok, 1);
      chk($sformatf("v%0d_latency", k), t1 - t0, LAT);
      chk($sformatf("v%0d_rsp_id", k), rsp_id, vecs[k].exp_id);
      chk($sformatf("v%0d_rsp_y", k), rsp_y, vecs[k].exp_y);
      chk($sformatf("v%0d_flags_zvn", k), {rsp_z, rsp_v, rsp_n}, {vecs[k].exp_z, vecs[k].exp_v, vecs[k].exp_n});
      chk($sformatf("v%0d_alu_op", k), alu_op, vecs[k].exp_id ? vecs[k].op1 : vecs[k].op0);
      @(negedge clk);
      chk($sformatf("v%0d_rsp_drop", k), rsp_valid, 0);
      chk($sformatf("v%0d_done_cnt", k), done_cnt, k + 1);
      chk($sformatf("v%0d_done_cnt_w2", k), w2_done_cnt, (k + 1) % 4);
    end

    // Backpressure: response held while both requesters keep asking.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive(2'b01, 5'h00, 5'h07, 32'd1, 32'd2, 32'd40, 32'd2);
    wait_ready(ok, t0);
    chk("bp_accept", ok, 1);
    @(posedge clk); #1;
    req_valid = 2'b11;
    wait_rsp(ok, t1);
    chk("bp_rsp_seen", ok, 1);
    bp_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(rsp_valid && rsp_id == 1'b0 && rsp_y == 32'd3 && req_ready == 2'b00 && busy && done_cnt == 16'd6))
        bp_ok = 1'b0;
    end
    chk("bp_stable", bp_ok, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = 2'b10;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_accept", req_ready, 2'b10);
    chk("bp_done_cnt", done_cnt, 7);

    // Reset while the accepted op is in EXEC.
    @(posedge clk); #1;
    drive(2'b11, 5'h02, 5'h04, 32'd10, 32'd1, 32'd20, 32'd2);
    @(negedge clk);
    chk("mid_busy_exec", busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done_cnt", {done_cnt, w2_done_cnt}, 0);
    chk("mid_rst_regs", {alu_op, alu_a, alu_b, rsp_id, rsp_y}, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_rsp", rsp_valid, 0);
    chk("post_rst_first_grant", req_ready, 2'b01);

    // Fairness: both requesters continuously valid for four operations.
    nr = 0;
    for (int i = 0; i < 60 && nr < 4; i++) begin
      if (req_ready != 2'b00) gq.push_back(int'(req_ready[1]));
      if (rsp_valid && rsp_ready) begin
        nr++;
        chk($sformatf("fair_rsp%0d_y", nr), rsp_y, rsp_id ? 32'd22 : 32'd11);
      end
      if (nr < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("fair_rsp_count", nr, 4);
    chk("fair_grant_count", gq.size(), 4);
    for (int i = 0; i < gq.size() && i < 4; i++)
      chk($sformatf("fair_grant%0d", i), gq[i], i % 2);
    chk("fair_done_cnt", done_cnt, 4);
    chk("fair_done_cnt_w2", w2_done_cnt, 0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
